ram_host_arb: RTL and testbench
===============================

Name: ram_host_arb

Overview:
- Two-host arbiter and response router that sits directly upstream of the single-port 32-bit data RAM.
- Merges the core's instruction-fetch port and data port (req/gnt/rvalid/err handshake) into one RAM request stream.
- Decodes the RAM address window and routes the 1-cycle-latency read data back to whichever host issued the request.
- Out-of-window accesses are terminated locally with an error response; they never reach the RAM.

Parameters:
- BaseAddr, 32'h0010_0000: byte address of RAM word 0.
- Depth, 16384: RAM size in 32-bit words; window is [BaseAddr, BaseAddr + 4*Depth).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  fetch request accepted this cycle
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch data
- instr_err_o  out  1  fetch error, qualified by instr_rvalid_o
- data_req_i  in  1  data request
- data_we_i  in  1  data write enable
- data_be_i  in  4  data byte enables
- data_addr_i  in  32  data byte address
- data_wdata_i  in  32  data write data
- data_gnt_o  out  1  data request accepted this cycle
- data_rvalid_o  out  1  data response valid; also asserted for writes
- data_rdata_o  out  32  data read data
- data_err_o  out  1  data error, qualified by data_rvalid_o
- ram_req_o  out  1  RAM request
- ram_we_o  out  1  RAM write enable
- ram_be_o  out  4  RAM byte enables
- ram_addr_o  out  32  byte offset into the RAM, i.e. addr minus BaseAddr
- ram_wdata_o  out  32  RAM write data
- ram_rvalid_i  in  1  RAM response valid, one cycle after ram_req_o
- ram_rdata_i  in  32  RAM read data

Behaviour:
- Clocking and reset: all state is updated on the rising edge of clk_i. While rst_ni is low, every gnt, rvalid, err and ram_req output is 0, and prio_q, pend_q and err_q are cleared. A response in flight when reset asserts is dropped.
- Grant timing: gnt is combinational in the same cycle as req; at most one host is granted per cycle. A host holds req and its address/data stable until it sees gnt.
- Arbitration:
  - If only one host requests, that host is granted.
  - If both request, the host given by prio_q is granted. prio_q = 1 selects data; reset value is 1.
  - On every grant, prio_q is loaded with the other host (round-robin).
- Window decode: in_range = (addr >= BaseAddr) && (addr - BaseAddr < 4*Depth), computed with 33-bit arithmetic so there is no wrap. addr[1:0] is passed through unchanged.
- RAM request: ram_req_o = granted && in_range. Mux selects granted host.
- Instruction port on the RAM side: drives ram_we_o = 0 and ram_be_o = 4'hF.
- Response tracking: on each grant, register host_q (0 = instr, 1 = data), pend_q = 1, and err_q = !in_range. With no grant, pend_q <= 0.
- Response, in the cycle after a grant:
  - The granted host's rvalid = pend_q && (err_q || ram_rvalid_i).
  - err = pend_q && err_q.
  - rdata = ram_rdata_i when err_q = 0, otherwise 32'h0.
- Non-selected host: rvalid = 0, err = 0, rdata = 32'h0.
- Back-to-back throughput: one grant per cycle; responses stay in order with one-cycle latency.
- Response vs. new grant: a response and a new grant can occur in the same cycle, for the same host or different hosts.
- Protocol check: ram_rvalid_i without a matching in-range pend_q is a protocol violation. It is ignored (no rvalid produced) and flagged by a simulation assertion.

Test Plan:
- Reset held 3 cycles with instr_req_i = data_req_i = 1 -> all gnt, rvalid and ram_req stay 0.
- Data write to BaseAddr+0x10, data 32'hDEADBEEF, be 4'hF; then data read of the same address -> ram_addr_o = 32'h10; data_rvalid_o one cycle after each grant; read returns 32'hDEADBEEF with err = 0.
- Both hosts request continuously for 6 cycles -> grants alternate data, instr, data, instr, ...; each response lands on the correct port one cycle after its grant.
- Instruction fetch at BaseAddr+4*Depth (just past the end) -> granted; ram_req_o = 0; next cycle instr_rvalid_o = 1, instr_err_o = 1, rdata = 0. Same at BaseAddr-4.
- Partial write be = 4'b0010, wdata 32'h0000AB00, to a word holding 32'h11223344; read back -> 32'h1122AB44.
- Reset asserted in the cycle after a grant -> no rvalid is produced on that host; after release, arbitration restarts with data priority.

Source files
------------

// File: rtl/ram_host_arb.sv
// Two-host (fetch/data) arbiter in front of the single-port data RAM.
// Round-robin grant, window decode with local error termination, and 1-cycle response routing.
module ram_host_arb #(
    parameter logic [31:0] BaseAddr = 32'h0010_0000,
    parameter int unsigned Depth    = 16384
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic        ram_rvalid_i,
    input  logic [31:0] ram_rdata_i
);

    localparam logic [32:0] WinBytes = 33'(Depth) << 2;

    logic        prio_q;
    logic        pend_q;
    logic        err_q;
    logic        host_q;

    logic        gnt_instr;
    logic        gnt_data;
    logic        any_gnt;
    logic        in_range;
    logic [31:0] sel_addr;
    logic [32:0] offset;
    logic        resp_live;

    // Request side: grant, address decode and RAM mux (all combinational)
    always_comb begin
        gnt_instr = rst_ni && instr_req_i && (!data_req_i || !prio_q);
        gnt_data  = rst_ni && data_req_i && (!instr_req_i || prio_q);
        any_gnt   = gnt_instr || gnt_data;
        sel_addr  = gnt_data ? data_addr_i : instr_addr_i;
        // 33-bit subtraction: a borrow into bit 32 means the address is below the window
        offset    = {1'b0, sel_addr} - {1'b0, BaseAddr};
        in_range  = !offset[32] && (offset < WinBytes);
    end

    assign instr_gnt_o = gnt_instr;
    assign data_gnt_o  = gnt_data;
    assign ram_req_o   = any_gnt && in_range;
    assign ram_we_o    = gnt_data && data_we_i;
    assign ram_be_o    = gnt_data ? data_be_i : 4'hF;
    assign ram_addr_o  = offset[31:0];
    assign ram_wdata_o = gnt_data ? data_wdata_i : 32'h0;

    // Response tracking register stage
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prio_q <= 1'b1;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
            host_q <= 1'b0;
        end else begin
            pend_q <= any_gnt;
            if (any_gnt) begin
                host_q <= gnt_data;
                err_q  <= !in_range;
                prio_q <= !gnt_data;
            end
        end
    end

    // Response side: a response pending when reset asserts is suppressed
    assign resp_live = rst_ni && pend_q;

    assign instr_rvalid_o = resp_live && !host_q && (err_q || ram_rvalid_i);
    assign instr_err_o    = resp_live && !host_q && err_q;
    assign instr_rdata_o  = (resp_live && !host_q && !err_q) ? ram_rdata_i : 32'h0;

    assign data_rvalid_o  = resp_live && host_q && (err_q || ram_rvalid_i);
    assign data_err_o     = resp_live && host_q && err_q;
    assign data_rdata_o   = (resp_live && host_q && !err_q) ? ram_rdata_i : 32'h0;

`ifndef SYNTHESIS
    // The RAM must only answer a request that was actually forwarded to it
    ram_rvalid_matches_req: assert property (
        @(posedge clk_i) disable iff (!rst_ni) ram_rvalid_i |-> (pend_q && !err_q)
    );
`endif

endmodule

// File: tb/tb_ram_host_arb.sv
// Scoreboard bench for ram_host_arb: directed vectors push expected responses,
// an independent monitor pops and compares them as responses appear.
module tb_ram_host_arb;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = 32'h0;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'h0;
    logic [31:0] data_addr_i = 32'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        ram_req_o, ram_we_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_addr_o, ram_wdata_o;
    logic        ram_rvalid_i = 1'b0;
    logic [31:0] ram_rdata_i = 32'h0;

    ram_host_arb dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Behavioural RAM, 1-cycle read latency, byte-enabled writes
    logic [31:0] mem [0:16383];
    initial for (int i = 0; i < 16384; i++) mem[i] = 32'h0;

    always @(posedge clk_i) begin
        ram_rvalid_i <= ram_req_o;
        if (ram_req_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b]) mem[ram_addr_o[15:2]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
                ram_rdata_i <= 32'h0;
            end else begin
                ram_rdata_i <= mem[ram_addr_o[15:2]];
            end
        end
    end

    typedef struct {
        logic        host;
        logic        err;
        logic        chk;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation
    always @(negedge clk_i) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            e = sbq.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_resp: no response seen, expected at cycle %0d host %0d", e.cyc, e.host);
        end
        if (instr_rvalid_o || data_rvalid_o) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rvalid: got instr=%0d data=%0d expected none (cycle %0d)",
                         instr_rvalid_o, data_rvalid_o, cyc);
            end else begin
                e = sbq.pop_front();
                chk("resp_port", {30'h0, instr_rvalid_o, data_rvalid_o}, e.host ? 32'h1 : 32'h2);
                chk("resp_cycle", cyc, e.cyc);
                chk("resp_err", e.host ? data_err_o : instr_err_o, e.err);
                if (e.chk) chk("resp_rdata", e.host ? data_rdata_o : instr_rdata_o, e.rdata);
                chk("idle_port_rdata", e.host ? instr_rdata_o : data_rdata_o, 32'h0);
            end
        end
    end

    task automatic issue(input logic is_data, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_ram_req, input logic [31:0] exp_ram_addr,
                         input logic exp_err, input logic chk_data, input logic [31:0] exp_rdata);
        @(posedge clk_i); #1;
        if (is_data) begin
            data_req_i = 1'b1; data_we_i = we; data_be_i = be;
            data_addr_i = addr; data_wdata_i = wdata;
        end else begin
            instr_req_i = 1'b1; instr_addr_i = addr;
        end
        @(negedge clk_i);
        chk("gnt", {30'h0, instr_gnt_o, data_gnt_o}, is_data ? 32'h1 : 32'h2);
        chk("ram_req", ram_req_o, exp_ram_req);
        if (exp_ram_req) begin
            chk("ram_addr", ram_addr_o, exp_ram_addr);
            chk("ram_we", ram_we_o, is_data && we);
            chk("ram_be", ram_be_o, is_data ? be : 4'hF);
            if (is_data && we) chk("ram_wdata", ram_wdata_o, wdata);
        end
        sbq.push_back('{host: is_data, err: exp_err, chk: chk_data, rdata: exp_rdata, cyc: cyc + 1});
        @(posedge clk_i); #1;
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        data_we_i   = 1'b0;
    endtask

    initial begin
        // Reset with both hosts requesting: nothing may be granted or forwarded
        instr_req_i = 1'b1; instr_addr_i = 32'h0010_0000;
        data_req_i  = 1'b1; data_addr_i  = 32'h0010_0004;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("reset_outputs", {27'h0, instr_gnt_o, data_gnt_o, ram_req_o, instr_rvalid_o, data_rvalid_o}, 32'h0);
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1; instr_req_i = 1'b0; data_req_i = 1'b0;

        // is_data we be addr wdata | ram_req ram_addr err chk rdata
        issue(1, 1, 4'hF, 32'h0010_0010, 32'hDEAD_BEEF, 1, 32'h0000_0010, 0, 0, 32'h0);
        issue(1, 0, 4'hF, 32'h0010_0010, 32'h0,        1, 32'h0000_0010, 0, 1, 32'hDEAD_BEEF);
        issue(1, 1, 4'hF, 32'h0010_0020, 32'h1122_3344, 1, 32'h0000_0020, 0, 0, 32'h0);
        issue(1, 1, 4'b0010, 32'h0010_0020, 32'h0000_AB00, 1, 32'h0000_0020, 0, 0, 32'h0);
        issue(1, 0, 4'hF, 32'h0010_0020, 32'h0,        1, 32'h0000_0020, 0, 1, 32'h1122_AB44);
        issue(1, 1, 4'hF, 32'h0010_FFFC, 32'hCAFE_F00D, 1, 32'h0000_FFFC, 0, 0, 32'h0);
        issue(0, 0, 4'hF, 32'h0010_FFFC, 32'h0,        1, 32'h0000_FFFC, 0, 1, 32'hCAFE_F00D);
        issue(0, 0, 4'hF, 32'h0011_0000, 32'h0,        0, 32'h0,         1, 1, 32'h0);
        issue(0, 0, 4'hF, 32'h000F_FFFC, 32'h0,        0, 32'h0,         1, 1, 32'h0);
        issue(1, 0, 4'hF, 32'hFFFF_FFFC, 32'h0,        0, 32'h0,         1, 1, 32'h0);
        issue(1, 0, 4'hF, 32'h0010_0012, 32'h0,        1, 32'h0000_0012, 0, 1, 32'hDEAD_BEEF);

        // Reset right after a grant: the in-flight response must vanish
        @(posedge clk_i); #1;
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h0010_0010;
        @(negedge clk_i);
        chk("pre_reset_gnt", {30'h0, instr_gnt_o, data_gnt_o}, 32'h1);
        @(posedge clk_i); #1;
        data_req_i = 1'b0; rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Both hosts request continuously: data first after reset, then alternate
        @(posedge clk_i); #1;
        instr_req_i = 1'b1; instr_addr_i = 32'h0010_FFFC;
        data_req_i  = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h0010_0010;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            if (k % 2 == 0) begin
                chk("rr_gnt", {30'h0, instr_gnt_o, data_gnt_o}, 32'h1);
                chk("rr_ram_addr", ram_addr_o, 32'h0000_0010);
                sbq.push_back('{host: 1'b1, err: 1'b0, chk: 1'b1, rdata: 32'hDEAD_BEEF, cyc: cyc + 1});
            end else begin
                chk("rr_gnt", {30'h0, instr_gnt_o, data_gnt_o}, 32'h2);
                chk("rr_ram_addr", ram_addr_o, 32'h0000_FFFC);
                sbq.push_back('{host: 1'b0, err: 1'b0, chk: 1'b1, rdata: 32'hCAFE_F00D, cyc: cyc + 1});
            end
        end
        @(posedge clk_i); #1;
        instr_req_i = 1'b0; data_req_i = 1'b0;

        repeat (3) @(posedge clk_i);
        #1 chk("scoreboard_drained", sbq.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
